three_bit_down_counter: RTL and testbench
=========================================

# three_bit_down_counter

Synchronous 3-bit down counter that subtracts a programmable step from its count on each enabled cycle. It uses a borrow-chain subtractor, the inverse of the team's ripple adder. It sits beside the up-counting blocks in the counters design and supplies count-down, terminal-zero and underflow indications to downstream timing logic. On underflow it wraps, reloads or saturates, depending on a build-time mode.

## Interface
Parameters:
- MODE, default 1: underflow policy.
  - 0 = wrap modulo 8.
  - 1 = auto-reload from the reload register.
  - 2 = saturate at 0 and halt.
- RELOAD_RST, default 3'd7: reset value of the internal reload register.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- load  input  1  loads load_val into count and into the reload register.
- load_val  input  3  value captured on load.
- en  input  1  decrement enable.
- step  input  3  amount subtracted per enabled cycle (0..7).
- count  output  3  current count, registered.
- zero  output  1  combinational; equals (count == 0).
- underflow  output  1  registered one-cycle pulse; high for the cycle after an enabled subtract produced a borrow.
- halted  output  1  registered; high while the FSM is in HALT (MODE 2 only).

## Operation
Reset (rst_n low at a clock edge):
- count=0, reload register=RELOAD_RST, underflow=0, halted=0, FSM=RUN.
- zero therefore reads 1 after reset.

Subtractor: diff[2:0] = count − step, with borrow = (step > count).
- Computed by a ripple of three full-subtractor cells.
- No wider intermediate; borrow is the only overflow information.

Priority per edge: rst_n low > load > en.
- load=1: count←load_val, reload←load_val, underflow←0, FSM←RUN. en is ignored that cycle.
- en=1, RUN, borrow=0: count←diff, underflow←0.
- en=1, RUN, borrow=1: underflow←1, and count depends on MODE:
  - MODE 0: count←diff (modulo 8).
  - MODE 1: count←reload.
  - MODE 2: count←0 and FSM←HALT.
- en=1 with step=0: count holds, underflow←0.
- en=0 and load=0: count holds, underflow←0.

FSM:
- Two states, RUN and HALT. HALT is reachable only in MODE 2.
- In HALT, en is ignored, count stays 0, and underflow is 0 after its single pulse.
- Only load or reset leaves HALT.

Exact hit: count=step with borrow=0 gives count←0 with no underflow. zero asserts the next cycle.

## Timing
- Latency: count, underflow and halted reflect en/load one clock after the sampling edge.
- zero follows count combinationally in the same cycle.
- underflow lasts exactly one cycle per borrowing subtract.
- Back-to-back borrowing subtracts (MODE 0/1) give a continuous high, one cycle per event.
- load and en together: load wins, and no underflow is generated even if count−step would borrow.
- Reset mid-operation: the next edge returns all outputs to their reset values regardless of load/en. A pending underflow is cleared.
- Reset in HALT returns the FSM to RUN.

## Structure
- Shared package `counter_pkg`:
  - MODE constants MODE_WRAP=0, MODE_RELOAD=1, MODE_SAT=2.
  - FSM state type with RUN, HALT.
  - COUNT_W=3.
- One sub-module, `three_bit_subtractor`:
  - Ports A[2:0], B[2:0], S[2:0], Bout.
  - Built from three full-subtractor stages with Bin of stage 0 tied to 0, mirroring the adder's carry chain.
- Top level holds the count register, reload register, underflow flop and FSM.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with load=1 and en=1 → count=0, zero=1, underflow=0, halted=0.
- MODE 1:
  - load 5, then en with step=2 for 3 cycles → count 3, 1, then 5 (reload).
  - underflow high only in the cycle after the third edge.
- MODE 0: load 1, en with step=3 → count=6, underflow pulses once. Next en with step=6 → count=0, zero=1, no underflow.
- MODE 2:
  - load 2, en with step=3 → count=0, underflow pulse, halted=1.
  - Further en with step=1 for 4 cycles → count stays 0, underflow stays 0.
  - load 4 → count=4, halted=0.
- Simultaneous: count=1, load=1 with load_val=6, en=1, step=7 → count=6, underflow=0.
- Subtractor exhaustive: all 64 (count, step) pairs with en=1 in MODE 0 → next count=(count−step) mod 8, underflow equal to (step>count).

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counters design: widths, underflow policies and FSM states.
package counter_pkg;

  localparam int COUNT_W = 3;

  localparam int MODE_WRAP   = 0;
  localparam int MODE_RELOAD = 1;
  localparam int MODE_SAT    = 2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage : counter_pkg

// File: rtl/three_bit_subtractor.sv
// Ripple-borrow subtractor S = A - B built from three full-subtractor cells,
// the mirror image of the ripple adder's carry chain.
module three_bit_subtractor
  import counter_pkg::*;
(
  input  logic [COUNT_W-1:0] A,
  input  logic [COUNT_W-1:0] B,
  output logic [COUNT_W-1:0] S,
  output logic               Bout
);

  logic [COUNT_W:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < COUNT_W; i++) begin : g_cell
    assign S[i]          = A[i] ^ B[i] ^ borrow[i];
    assign borrow[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
  end

  assign Bout = borrow[COUNT_W];

endmodule : three_bit_subtractor

// File: rtl/three_bit_down_counter.sv
// Programmable-step 3-bit down counter with wrap / reload / saturate-and-halt
// underflow policy selected at build time.
module three_bit_down_counter
  import counter_pkg::*;
#(
  parameter int                 MODE       = 1,
  parameter logic [COUNT_W-1:0] RELOAD_RST = 3'd7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               en,
  input  logic [COUNT_W-1:0] step,
  output logic [COUNT_W-1:0] count,
  output logic               zero,
  output logic               underflow,
  output logic               halted
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] reload_q, reload_d;
  logic [COUNT_W-1:0] count_d;
  logic               underflow_d;
  logic [COUNT_W-1:0] diff;
  logic               borrow;

  three_bit_subtractor u_sub (
    .A    (count),
    .B    (step),
    .S    (diff),
    .Bout (borrow)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    count_d     = count;
    reload_d    = reload_q;
    underflow_d = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = RUN;
    end else if (en && state_q == RUN) begin
      if (!borrow) begin
        count_d = diff;
      end else begin
        underflow_d = 1'b1;
        if (MODE == MODE_RELOAD) begin
          count_d = reload_q;
        end else if (MODE == MODE_SAT) begin
          count_d = '0;
          state_d = HALT;
        end else begin
          count_d = diff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count     <= '0;
      reload_q  <= RELOAD_RST;
      underflow <= 1'b0;
      state_q   <= RUN;
    end else begin
      count     <= count_d;
      reload_q  <= reload_d;
      underflow <= underflow_d;
      state_q   <= state_d;
    end
  end

  assign zero   = (count == '0);
  assign halted = (state_q == HALT);

endmodule : three_bit_down_counter

// File: tb/tb_three_bit_down_counter.sv
// Scoreboard bench: one instance per underflow policy; the driver queues the
// expected response for each issued cycle and a monitor compares after each edge.
module tb_three_bit_down_counter;

  typedef struct packed {
    logic [2:0] count;
    logic       zero;
    logic       underflow;
    logic       halted;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld [3];
  logic [2:0] lv [3];
  logic       en [3];
  logic [2:0] st [3];
  logic [2:0] cnt [3];
  logic       zr [3];
  logic       uf [3];
  logic       hl [3];

  resp_t q0[$];
  resp_t q1[$];
  resp_t q2[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  three_bit_down_counter #(.MODE(0), .RELOAD_RST(3'd7)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .load(ld[0]), .load_val(lv[0]), .en(en[0]), .step(st[0]),
    .count(cnt[0]), .zero(zr[0]), .underflow(uf[0]), .halted(hl[0]));

  three_bit_down_counter #(.MODE(1), .RELOAD_RST(3'd7)) dut_reload (
    .clk(clk), .rst_n(rst_n), .load(ld[1]), .load_val(lv[1]), .en(en[1]), .step(st[1]),
    .count(cnt[1]), .zero(zr[1]), .underflow(uf[1]), .halted(hl[1]));

  three_bit_down_counter #(.MODE(2), .RELOAD_RST(3'd7)) dut_sat (
    .clk(clk), .rst_n(rst_n), .load(ld[2]), .load_val(lv[2]), .en(en[2]), .step(st[2]),
    .count(cnt[2]), .zero(zr[2]), .underflow(uf[2]), .halted(hl[2]));

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got {count,zero,uf,halted}=%b required %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic resp_t mk(input logic [2:0] c, input logic u, input logic h);
    resp_t r;
    r.count     = c;
    r.zero      = (c == 3'd0);
    r.underflow = u;
    r.halted    = h;
    return r;
  endfunction

  // Monitor: one queued expectation per DUT is retired after each rising edge.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("wrap", {cnt[0], zr[0], uf[0], hl[0]}, e);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("reload", {cnt[1], zr[1], uf[1], hl[1]}, e);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check("sat", {cnt[2], zr[2], uf[2], hl[2]}, e);
      end
    end
  end

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      ld[i] = 1'b0; en[i] = 1'b0; lv[i] = 3'd0; st[i] = 3'd0;
    end
  endtask

  task automatic push(input int m, input resp_t r);
    case (m)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  // One cycle on DUT m; the other instances sit idle and unchecked.
  task automatic drive(input int m, input logic l, input logic [2:0] lval, input logic e,
                       input logic [2:0] s, input logic [2:0] ec, input logic eu, input logic eh);
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
    ld[m] = l; lv[m] = lval; en[m] = e; st[m] = s;
    push(m, mk(ec, eu, eh));
  endtask

  // Reset with load and en both asserted; reset must dominate on every instance.
  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
        ld[i] = 1'b1; lv[i] = 3'd5; en[i] = 1'b1; st[i] = 3'd1;
        push(i, mk(3'd0, 1'b0, 1'b0));
      end
    end
  endtask

  initial begin
    idle_all();
    reset_cycles(2);

    // Reload policy: 5 -> 3 -> 1 -> reload 5 with a single underflow pulse.
    drive(1, 1, 3'd5, 0, 3'd0, 3'd5, 0, 0);
    drive(1, 0, 3'd0, 1, 3'd2, 3'd3, 0, 0);
    drive(1, 0, 3'd0, 1, 3'd2, 3'd1, 0, 0);
    drive(1, 0, 3'd0, 1, 3'd2, 3'd5, 1, 0);
    drive(1, 0, 3'd0, 0, 3'd2, 3'd5, 0, 0);
    drive(1, 0, 3'd0, 1, 3'd0, 3'd5, 0, 0);
    // Back-to-back borrows: continuous underflow, reload value 5 each time.
    drive(1, 0, 3'd0, 1, 3'd6, 3'd5, 1, 0);
    drive(1, 0, 3'd0, 1, 3'd7, 3'd5, 1, 0);
    drive(1, 0, 3'd0, 1, 3'd5, 3'd0, 0, 0);
    // Simultaneous load and borrowing en: load wins, no underflow.
    drive(1, 1, 3'd1, 0, 3'd0, 3'd1, 0, 0);
    drive(1, 1, 3'd6, 1, 3'd7, 3'd6, 0, 0);

    // Wrap policy directed vectors.
    drive(0, 1, 3'd1, 0, 3'd0, 3'd1, 0, 0);
    drive(0, 0, 3'd0, 1, 3'd3, 3'd6, 1, 0);
    drive(0, 0, 3'd0, 1, 3'd6, 3'd0, 0, 0);

    // Saturate policy: halt, ignore en, recover on load.
    drive(2, 1, 3'd2, 0, 3'd0, 3'd2, 0, 0);
    drive(2, 0, 3'd0, 1, 3'd3, 3'd0, 1, 1);
    for (int k = 0; k < 4; k++) drive(2, 0, 3'd0, 1, 3'd1, 3'd0, 0, 1);
    drive(2, 1, 3'd4, 0, 3'd0, 3'd4, 0, 0);
    drive(2, 0, 3'd0, 1, 3'd5, 3'd0, 1, 1);

    // Reset while halted returns to RUN and restores the reload register.
    reset_cycles(1);
    drive(2, 0, 3'd0, 1, 3'd2, 3'd0, 1, 1);
    drive(1, 0, 3'd0, 1, 3'd1, 3'd7, 1, 0);

    // Exhaustive subtractor sweep on the wrap instance.
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < 8; s++) begin
        logic [2:0] cv, sv, dv;
        cv = 3'(c);
        sv = 3'(s);
        dv = 3'((c - s) & 7);
        drive(0, 1, cv, 0, 3'd0, cv, 0, 0);
        drive(0, 0, 3'd0, 1, sv, dv, (s > c), 0);
      end
    end

    @(negedge clk);
    idle_all();
    @(posedge clk);
    #2;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations required 0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_three_bit_down_counter
